// File: rtl/fir_pkg.sv
// fir_pkg: shared constants and FSM state type for the FIR sample feeder.
//   DW_DEF      - default sample width (matches the filter data width)
//   DEPTH_DEF   - default FIFO depth
//   TIMEOUT_DEF - default number of cycles spent in WAIT before giving up
//   state_t     - feeder FSM state (ST_IDLE, ST_WAIT)
package fir_pkg;

    localparam int DW_DEF      = 16;
    localparam int DEPTH_DEF   = 16;
    localparam int TIMEOUT_DEF = 15;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/feed_fifo.sv
// feed_fifo: synchronous FIFO with a registered head word.
// The head register always holds the oldest entry while the FIFO is not
// empty, so the consumer can latch it in the same cycle it pops.
// Ports:
//   clk, reset         - clock, asynchronous active-high reset
//   push, push_data    - write request and data (ignored while full)
//   pop                - read request (ignored while empty)
//   head               - oldest entry (valid while !empty)
//   level              - occupancy, 0..DEPTH
//   full, empty        - occupancy flags
module feed_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [DW-1:0]            push_data,
    input  logic                     pop,
    output logic [DW-1:0]            head,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic [DW-1:0] head_r;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == LW'(0));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign level   = count;
    assign head    = head_r;

    // Storage array write port; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, occupancy and head register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= AW'(0);
            rd_ptr <= AW'(0);
            count  <= LW'(0);
            head_r <= DW'(0);
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
            // Next head: the following stored entry, or the incoming word
            // when it becomes the only entry.
            if (do_pop) begin
                if (count >= LW'(2)) begin
                    head_r <= mem[rd_ptr + AW'(1)];
                end else if (do_push) begin
                    head_r <= push_data;
                end else begin
                    head_r <= head_r;
                end
            end else if (do_push && empty) begin
                head_r <= push_data;
            end else begin
                head_r <= head_r;
            end
        end
    end

endmodule

// File: rtl/fir_feeder.sv
// fir_feeder: buffers input samples and hands them to the 8-tap FIR one at a
// time, waiting for the filter's output flag (or a timeout) between issues.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   wr_en, wr_data        - sample push side
//   wr_full, level        - FIFO full flag and occupancy
//   enable                - permits new issues (never aborts one in flight)
//   fir_data, fir_ready   - filter data_in and single-cycle data_in_ready
//   fir_done              - filter data_out_flag
//   ovf_clr, overflow     - sticky dropped-push flag and its clear
//   timeout_err           - one-cycle pulse when the filter never answered
module fir_feeder
    import fir_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [DW-1:0]          wr_data,
    output logic                   wr_full,
    output logic [$clog2(DEPTH):0] level,
    input  logic                   enable,
    output logic [DW-1:0]          fir_data,
    output logic                   fir_ready,
    input  logic                   fir_done,
    input  logic                   ovf_clr,
    output logic                   overflow,
    output logic                   timeout_err
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic [DW-1:0] head;
    logic          empty;
    logic          issue;

    // A pop is only requested from IDLE, so fir_done in IDLE has no effect.
    assign issue = (state == ST_IDLE) && enable && !empty;

    feed_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (issue),
        .head      (head),
        .level     (level),
        .full      (wr_full),
        .empty     (empty)
    );

    // Issue/wait FSM with the timeout counter; fir_ready and timeout_err
    // default low so each is a single-cycle pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            wait_cnt    <= CW'(0);
            fir_data    <= DW'(0);
            fir_ready   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            fir_ready   <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (issue) begin
                        fir_data  <= head;
                        fir_ready <= 1'b1;
                        wait_cnt  <= CW'(0);
                        state     <= ST_WAIT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt + CW'(1);
                    if (fir_done) begin
                        state <= ST_IDLE;
                    end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                        // Abandon the sample; it is not retried.
                        timeout_err <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky overflow; a dropped push in the same cycle as a clear wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (wr_en && wr_full) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end else begin
            overflow <= overflow;
        end
    end

endmodule

// File: tb/tb_fir_feeder.sv
// tb_fir_feeder: directed self-checking bench for fir_feeder with a filter
// model answering 4 edges after each sampled strobe.
module tb_fir_feeder;

    localparam int DW = 16;

    logic          clk;
    logic          reset;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          wr_full;
    logic [4:0]    level;
    logic          enable;
    logic [DW-1:0] fir_data;
    logic          fir_ready;
    logic          fir_done;
    logic          ovf_clr;
    logic          overflow;
    logic          timeout_err;

    logic          filter_on;
    logic          force_done;
    logic [3:0]    sr;

    int            tests;
    int            fails;
    int            cyc;

    logic [DW-1:0] issued [$];
    int            issue_cyc [$];
    int            to_cyc [$];
    bit            prev_ready;
    bit            consec_err;

    fir_feeder #(.DW(16), .DEPTH(16), .TIMEOUT(15)) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .wr_full     (wr_full),
        .level       (level),
        .enable      (enable),
        .fir_data    (fir_data),
        .fir_ready   (fir_ready),
        .fir_done    (fir_done),
        .ovf_clr     (ovf_clr),
        .overflow    (overflow),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Filter model: strobe sampled at edge N+1 -> fir_done high for edge N+5.
    always @(posedge clk or posedge reset) begin
        if (reset) sr <= 4'd0;
        else       sr <= {sr[2:0], fir_ready};
    end
    assign fir_done = (sr[3] & filter_on) | force_done;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (fir_ready) begin
            issued.push_back(fir_data);
            issue_cyc.push_back(cyc);
        end
        if (timeout_err) to_cyc.push_back(cyc);
        if (fir_ready && prev_ready) consec_err = 1'b1;
        prev_ready = fir_ready;
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic push(input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic clear_logs;
        issued.delete();
        issue_cyc.delete();
        to_cyc.delete();
        consec_err = 1'b0;
    endtask

    task automatic do_reset;
        reset = 1'b1; wr_en = 1'b0; enable = 1'b0; ovf_clr = 1'b0;
        force_done = 1'b0; filter_on = 1'b1; wr_data = 16'h0000;
        run(2);
        reset = 1'b0;
        tick();
        clear_logs();
    endtask

    task automatic test_reset;
        reset = 1'b1; wr_en = 1'b0; enable = 1'b0; ovf_clr = 1'b0;
        force_done = 1'b0; filter_on = 1'b1; wr_data = 16'h0000;
        run(2);
        tests++; if (fir_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %0h expected 0", fir_ready); end
        tests++; if (fir_data !== 16'h0000) begin fails++; $display("FAIL reset_data: got %0h expected 0", fir_data); end
        tests++; if (level !== 5'd0) begin fails++; $display("FAIL reset_level: got %0d expected 0", level); end
        tests++; if (wr_full !== 1'b0) begin fails++; $display("FAIL reset_full: got %0h expected 0", wr_full); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %0h expected 0", overflow); end
        tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL reset_to: got %0h expected 0", timeout_err); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic;
        do_reset();
        enable = 1'b1;
        push(16'h0001); push(16'h0002); push(16'h0003);
        run(25);
        tests++; if (issued.size() !== 3) begin fails++; $display("FAIL basic_count: got %0d expected 3", issued.size()); end
        if (issued.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                logic [DW-1:0] exp_v;
                exp_v = 16'(i + 1);
                tests++; if (issued[i] !== exp_v) begin fails++; $display("FAIL basic_data[%0d]: got %0h expected %0h", i, issued[i], exp_v); end
            end
            tests++; if (issue_cyc[1] - issue_cyc[0] !== 6) begin fails++; $display("FAIL basic_gap01: got %0d expected 6", issue_cyc[1] - issue_cyc[0]); end
            tests++; if (issue_cyc[2] - issue_cyc[1] !== 6) begin fails++; $display("FAIL basic_gap12: got %0d expected 6", issue_cyc[2] - issue_cyc[1]); end
        end
        tests++; if (level !== 5'd0) begin fails++; $display("FAIL basic_level: got %0d expected 0", level); end
        tests++; if (consec_err !== 1'b0) begin fails++; $display("FAIL basic_consec_ready: got %0h expected 0", consec_err); end
    endtask

    task automatic test_overflow;
        do_reset();
        for (int i = 0; i < 17; i++) push(16'h0100 + 16'(i));
        tests++; if (wr_full !== 1'b1) begin fails++; $display("FAIL ovf_full: got %0h expected 1", wr_full); end
        tests++; if (level !== 5'd16) begin fails++; $display("FAIL ovf_level: got %0d expected 16", level); end
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_set: got %0h expected 1", overflow); end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_clr: got %0h expected 0", overflow); end
        clear_logs();
        enable = 1'b1;
        run(106);
        tests++; if (issued.size() !== 16) begin fails++; $display("FAIL ovf_count: got %0d expected 16", issued.size()); end
        if (issued.size() == 16) begin
            for (int i = 0; i < 16; i++) begin
                logic [DW-1:0] exp_v;
                exp_v = 16'h0100 + 16'(i);
                tests++; if (issued[i] !== exp_v) begin fails++; $display("FAIL ovf_data[%0d]: got %0h expected %0h", i, issued[i], exp_v); end
            end
        end
        tests++; if (level !== 5'd0) begin fails++; $display("FAIL ovf_drain_level: got %0d expected 0", level); end
        tests++; if (wr_full !== 1'b0) begin fails++; $display("FAIL ovf_drain_full: got %0h expected 0", wr_full); end
    endtask

    task automatic test_timeout;
        do_reset();
        filter_on = 1'b0;
        push(16'h00A1); push(16'h00A2);
        enable = 1'b1;
        run(40);
        tests++; if (to_cyc.size() !== 2) begin fails++; $display("FAIL to_count: got %0d expected 2", to_cyc.size()); end
        tests++; if (issued.size() !== 2) begin fails++; $display("FAIL to_issues: got %0d expected 2", issued.size()); end
        if (to_cyc.size() == 2 && issued.size() == 2) begin
            tests++; if (to_cyc[0] - issue_cyc[0] !== 15) begin fails++; $display("FAIL to_delay: got %0d expected 15", to_cyc[0] - issue_cyc[0]); end
            tests++; if (issue_cyc[1] - to_cyc[0] !== 1) begin fails++; $display("FAIL to_reissue: got %0d expected 1", issue_cyc[1] - to_cyc[0]); end
            tests++; if (issued[1] !== 16'h00A2) begin fails++; $display("FAIL to_next_data: got %0h expected a2", issued[1]); end
        end
        filter_on = 1'b1;
    endtask

    task automatic test_enable_drop;
        int e;
        do_reset();
        push(16'h000A); push(16'h000B); push(16'h000C);
        enable = 1'b1;
        for (int i = 0; i < 10 && issued.size() == 0; i++) tick();
        tests++; if (issued.size() !== 1) begin fails++; $display("FAIL en_first_issue: got %0d expected 1", issued.size()); end
        tick();
        enable = 1'b0;
        run(15);
        tests++; if (issued.size() !== 1) begin fails++; $display("FAIL en_hold: got %0d expected 1", issued.size()); end
        tests++; if (to_cyc.size() !== 0) begin fails++; $display("FAIL en_done_taken: got %0d timeouts expected 0", to_cyc.size()); end
        tests++; if (level !== 5'd2) begin fails++; $display("FAIL en_level: got %0d expected 2", level); end
        e = cyc;
        enable = 1'b1;
        run(2);
        tests++; if (issue_cyc.size() !== 2) begin fails++; $display("FAIL en_resume: got %0d expected 2", issue_cyc.size()); end
        else begin
            tests++; if (issue_cyc[1] !== e + 1) begin fails++; $display("FAIL en_resume_cyc: got %0d expected %0d", issue_cyc[1], e + 1); end
        end
        run(20);
    endtask

    task automatic test_reset_wait;
        do_reset();
        filter_on = 1'b0;
        push(16'h0011); push(16'h0022);
        enable = 1'b1;
        for (int i = 0; i < 10 && issued.size() == 0; i++) tick();
        run(2);
        reset = 1'b1;
        #1;
        tests++; if (fir_ready !== 1'b0) begin fails++; $display("FAIL rw_ready: got %0h expected 0", fir_ready); end
        tests++; if (fir_data !== 16'h0000) begin fails++; $display("FAIL rw_data: got %0h expected 0", fir_data); end
        tests++; if (level !== 5'd0) begin fails++; $display("FAIL rw_level: got %0d expected 0", level); end
        tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL rw_to: got %0h expected 0", timeout_err); end
        tick();
        reset = 1'b0;
        run(2);
        force_done = 1'b1;
        tick();
        force_done = 1'b0;
        run(20);
        tests++; if (issued.size() !== 1) begin fails++; $display("FAIL rw_no_strobe: got %0d issues expected 1", issued.size()); end
        tests++; if (to_cyc.size() !== 0) begin fails++; $display("FAIL rw_no_timeout: got %0d expected 0", to_cyc.size()); end
        tests++; if (level !== 5'd0) begin fails++; $display("FAIL rw_level_after: got %0d expected 0", level); end
        filter_on = 1'b1;
    endtask

    task automatic test_push_pop;
        do_reset();
        push(16'h0055);
        tests++; if (level !== 5'd1) begin fails++; $display("FAIL pp_level_pre: got %0d expected 1", level); end
        enable  = 1'b1;
        wr_en   = 1'b1;
        wr_data = 16'h0066;
        tick();
        wr_en = 1'b0;
        tests++; if (level !== 5'd1) begin fails++; $display("FAIL pp_level: got %0d expected 1", level); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL pp_ovf: got %0h expected 0", overflow); end
        run(15);
        tests++; if (issued.size() !== 2) begin fails++; $display("FAIL pp_count: got %0d expected 2", issued.size()); end
        else begin
            tests++; if (issued[0] !== 16'h0055) begin fails++; $display("FAIL pp_data0: got %0h expected 55", issued[0]); end
            tests++; if (issued[1] !== 16'h0066) begin fails++; $display("FAIL pp_data1: got %0h expected 66", issued[1]); end
        end
        tests++; if (level !== 5'd0) begin fails++; $display("FAIL pp_level_end: got %0d expected 0", level); end
    endtask

    initial begin
        tests = 0; fails = 0; cyc = 0;
        prev_ready = 1'b0; consec_err = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_timeout();
        test_enable_drop();
        test_reset_wait();
        test_push_pop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
